// File: rtl/stoch_signed_argmax_sched.sv
// Windowed argmax over NUM_INPUTS signed (p/m) stochastic streams; routes the winner's streams out.
// Latency: start to done = WINDOW+NUM_INPUTS-1 cycles; y_p/y_m follow the selected input by 1 cycle.
// No backpressure: start is taken only in IDLE, and a start while busy is dropped, not queued.
module stoch_signed_argmax_sched #(
  parameter int NUM_INPUTS   = 4,
  parameter int COUNTER_SIZE = 10,
  parameter int WINDOW       = 256,
  localparam int IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] as_p,
  input  logic [NUM_INPUTS-1:0] as_m,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      sel_idx,
  output logic                  out_vld,
  output logic                  y_p,
  output logic                  y_m
);

  localparam int STEP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  CAND_LAST = IDX_W'(NUM_INPUTS - 1);
  localparam logic signed [COUNTER_SIZE-1:0] ACC_MAX = {1'b0, {(COUNTER_SIZE-1){1'b1}}};
  localparam logic signed [COUNTER_SIZE-1:0] ACC_MIN = {1'b1, {(COUNTER_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CMP   = 2'd2
  } state_t;

  state_t                          state_q;
  logic [STEP_W-1:0]               step_q;
  logic signed [COUNTER_SIZE-1:0]  acc_q [NUM_INPUTS];
  logic signed [COUNTER_SIZE-1:0]  acc_d [NUM_INPUTS];
  logic signed [COUNTER_SIZE-1:0]  best_q;
  logic [IDX_W-1:0]                best_idx_q;
  logic [IDX_W-1:0]                cand_q;
  logic                            cand_wins;
  logic [IDX_W-1:0]                win_idx;
  logic                            busy_q;
  logic                            done_q;
  logic [IDX_W-1:0]                sel_idx_q;
  logic                            out_vld_q;
  logic                            y_p_q;
  logic                            y_m_q;

  // Per-input saturating step: (1,0) counts up, (0,1) counts down, equal bits hold.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      acc_d[i] = acc_q[i];
      if (as_p[i] && !as_m[i] && (acc_q[i] != ACC_MAX)) begin
        acc_d[i] = acc_q[i] + COUNTER_SIZE'(1);
      end else if (as_m[i] && !as_p[i] && (acc_q[i] != ACC_MIN)) begin
        acc_d[i] = acc_q[i] - COUNTER_SIZE'(1);
      end
    end
  end

  // Serial compare: strict greater-than so ties keep the lower index.
  always_comb begin
    cand_wins = (acc_q[cand_q] > best_q);
    win_idx   = cand_wins ? cand_q : best_idx_q;
  end

  // Control FSM with registered status and stream outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cand_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_idx_q  <= '0;
      out_vld_q  <= 1'b0;
      y_p_q      <= 1'b0;
      y_m_q      <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // Old selection keeps streaming until the edge after done.
      y_p_q  <= out_vld_q ? as_p[sel_idx_q] : 1'b0;
      y_m_q  <= out_vld_q ? as_m[sel_idx_q] : 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ACCUM;
            step_q  <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NUM_INPUTS; i++) begin
              acc_q[i] <= '0;
            end
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            acc_q[i] <= acc_d[i];
          end
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_LAST) begin
            // Seed the comparison with input 0's final count.
            best_q     <= acc_d[0];
            best_idx_q <= '0;
            cand_q     <= IDX_W'(1);
            if (NUM_INPUTS == 1) begin
              state_q   <= S_IDLE;
              done_q    <= 1'b1;
              sel_idx_q <= '0;
              out_vld_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state_q <= S_CMP;
            end
          end
        end
        S_CMP: begin
          if (cand_wins) begin
            best_q     <= acc_q[cand_q];
            best_idx_q <= cand_q;
          end
          cand_q <= cand_q + IDX_W'(1);
          if (cand_q == CAND_LAST) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            sel_idx_q <= win_idx;
            out_vld_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_idx = sel_idx_q;
  assign out_vld = out_vld_q;
  assign y_p     = y_p_q;
  assign y_m     = y_m_q;

endmodule

// File: tb/tb_stoch_signed_argmax_sched.sv
// Randomized bench for stoch_signed_argmax_sched against an integer argmax model.
// Two instances: a main one (WINDOW=16, 10-bit counters) and a saturation one (WINDOW=32, 4-bit).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_stoch_signed_argmax_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int CS  = 10;
  localparam int WB  = 32;
  localparam int CSB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_a, start_b;
  logic [N-1:0] p_a, m_a, p_b, m_b;
  logic         busy_a, done_a, vld_a, yp_a, ym_a;
  logic         busy_b, done_b, vld_b, yp_b, ym_b;
  logic [1:0]   sel_a, sel_b;

  stoch_signed_argmax_sched #(.NUM_INPUTS(N), .COUNTER_SIZE(CS), .WINDOW(W)) dut_a (
    .CLK(clk), .RST(rst), .start(start_a), .as_p(p_a), .as_m(m_a),
    .busy(busy_a), .done(done_a), .sel_idx(sel_a), .out_vld(vld_a), .y_p(yp_a), .y_m(ym_a)
  );

  stoch_signed_argmax_sched #(.NUM_INPUTS(N), .COUNTER_SIZE(CSB), .WINDOW(WB)) dut_b (
    .CLK(clk), .RST(rst), .start(start_b), .as_p(p_b), .as_m(m_b),
    .busy(busy_b), .done(done_b), .sel_idx(sel_b), .out_vld(vld_b), .y_p(yp_b), .y_m(ym_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference view of the main instance's output selection.
  logic m_vld;
  int   m_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_add(input int a, input int d, input int cs);
    int hi, lo, r;
    hi = (1 << (cs - 1)) - 1;
    lo = -(1 << (cs - 1));
    r  = a + d;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic int delta(input logic p, input logic m);
    if (p && !m) return 1;
    if (m && !p) return -1;
    return 0;
  endfunction

  // Stimulus patterns for window cycle t (1-based).
  function automatic void gen(input int mode, input int t,
                              output logic [N-1:0] p, output logic [N-1:0] m);
    int v;
    p = '0;
    m = '0;
    case (mode)
      0: begin p = N'($urandom); m = N'($urandom); end
      1: p[2] = 1'b1;
      2: begin p[1] = 1'b1; p[3] = 1'b1; end
      3: begin m = '1; if ((t % 2) != 0) m[1] = 1'b0; end
      4: begin p = '1; m = '1; end
      default: begin
        for (int i = 0; i < N; i++) begin
          v = $urandom_range(0, 3);
          if (v < i) p[i] = 1'b1;
          else if (v > i) m[i] = 1'b1;
        end
      end
    endcase
  endfunction

  // One clock of the main instance; checks the routed streams against the model.
  task automatic tick_a(input logic [N-1:0] p, input logic [N-1:0] m, input logic st,
                        output logic d);
    logic ep, em;
    p_a = p;
    m_a = m;
    start_a = st;
    ep = m_vld ? p[m_sel] : 1'b0;
    em = m_vld ? m[m_sel] : 1'b0;
    @(posedge clk);
    #1;
    chk("y_p", yp_a, ep);
    chk("y_m", ym_a, em);
    d = done_a;
  endtask

  task automatic idle_ticks(input int n);
    logic d;
    for (int i = 0; i < n; i++) begin
      tick_a(N'($urandom), N'($urandom), 1'b0, d);
      chk("no_spurious_done", d, 0);
    end
  endtask

  task automatic do_reset();
    logic d;
    rst = 1'b1;
    m_vld = 1'b0;
    m_sel = 0;
    tick_a(N'($urandom), N'($urandom), 1'b0, d);
    tick_a(N'($urandom), N'($urandom), 1'b0, d);
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_vld", vld_b, 0);
    chk("rst_b_y", {yp_b, ym_b}, 0);
  endtask

  // Full evaluation on the main instance; poke issues starts while busy.
  task automatic run_eval_a(input int mode, input bit poke);
    int acc [N];
    int best;
    logic [N-1:0] p, m;
    logic d;
    for (int i = 0; i < N; i++) acc[i] = 0;
    tick_a(N'($urandom), N'($urandom), 1'b1, d);
    chk("done_at_start", d, 0);
    chk("busy_after_start", busy_a, 1);
    for (int t = 1; t <= W; t++) begin
      gen(mode, t, p, m);
      for (int i = 0; i < N; i++) acc[i] = sat_add(acc[i], delta(p[i], m[i]), CS);
      tick_a(p, m, poke && (t == 5), d);
      chk("done_in_accum", d, 0);
    end
    for (int k = 1; k < N; k++) begin
      tick_a(N'($urandom), N'($urandom), poke && (k == 1), d);
      chk((k == N - 1) ? "done_pulse" : "done_in_cmp", d, (k == N - 1) ? 1 : 0);
    end
    best = 0;
    for (int k = 1; k < N; k++) if (acc[k] > acc[best]) best = k;
    chk("sel_idx", sel_a, best);
    chk("out_vld", vld_a, 1);
    chk("busy_after_done", busy_a, 0);
    m_sel = best;
    m_vld = 1'b1;
  endtask

  // Evaluation on the saturation instance with a bounded wait for done.
  task automatic run_eval_b(input int mode);
    int acc [N];
    int best, lat;
    bit seen;
    logic [N-1:0] p, m;
    for (int i = 0; i < N; i++) acc[i] = 0;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    chk("b_busy", busy_b, 1);
    for (int t = 1; t <= WB; t++) begin
      if (mode == 9) begin
        p = '0;
        m = '0;
        p[0] = 1'b1;
        p[1] = (t <= 30);
      end else begin
        gen(mode, t, p, m);
      end
      for (int i = 0; i < N; i++) acc[i] = sat_add(acc[i], delta(p[i], m[i]), CSB);
      p_b = p;
      m_b = m;
      @(posedge clk);
      #1;
      chk("b_done_early", done_b, 0);
    end
    lat = WB;
    seen = 0;
    while (!seen && (lat < WB + N + 4)) begin
      p_b = N'($urandom);
      m_b = N'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (done_b) seen = 1;
    end
    chk("b_latency", lat, WB + N - 1);
    best = 0;
    for (int k = 1; k < N; k++) if (acc[k] > acc[best]) best = k;
    chk("b_sel_idx", sel_b, best);
  endtask

  initial begin
    logic d;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    p_a = '0; m_a = '0; p_b = '0; m_b = '0;
    m_vld = 1'b0;
    m_sel = 0;

    do_reset();
    idle_ticks(3);

    run_eval_a(1, 1'b0);      // single positive input wins
    idle_ticks(4);
    run_eval_a(2, 1'b0);      // tie goes to lower index
    idle_ticks(2);
    run_eval_a(3, 1'b0);      // all negative, least negative wins
    run_eval_a(4, 1'b0);      // start in the done cycle; all zero -> index 0
    for (int r = 0; r < 6; r++) begin
      run_eval_a((r % 2 == 0) ? 0 : 5, 1'b0);
      idle_ticks($urandom_range(0, 2));
    end
    run_eval_a(1, 1'b1);      // starts while busy are dropped
    idle_ticks(W + N + 2);

    do_reset();               // reset from IDLE with a valid winner

    run_eval_a(2, 1'b0);
    tick_a(N'($urandom), N'($urandom), 1'b1, d);
    for (int i = 0; i < 4; i++) tick_a(N'($urandom), N'($urandom), 1'b0, d);
    do_reset();               // reset mid-ACCUM
    idle_ticks(W + N + 2);
    chk("vld_after_abort", vld_a, 0);

    tick_a(N'($urandom), N'($urandom), 1'b1, d);
    for (int i = 0; i < W + 1; i++) tick_a(N'($urandom), N'($urandom), 1'b0, d);
    do_reset();               // reset mid-CMP
    idle_ticks(N + 2);
    chk("vld_after_cmp_abort", vld_a, 0);

    run_eval_a(5, 1'b0);      // recovery after aborts
    idle_ticks(3);

    run_eval_b(9);            // both saturate at +7 -> index 0
    for (int r = 0; r < 3; r++) run_eval_b(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
